// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes and the "no register" address.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register address meaning "no destination" for the default 4-bit regfile.
    localparam logic [3:0] RNONE   = 4'hF;

    // Architectural status codes.
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    // Writeback control state: RUN retires normally, HALTED freezes architectural effects.
    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stat_encode.sv
// Combinational status encoder: error flags and icode of the M-stage instruction to a status code.
module wb_stat_encode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       instr_valid,
    input  logic       imem_error,
    input  logic       dmem_error,
    output stat_t      stat
);

    // Fetch errors outrank decode errors, which outrank data-memory errors, which outrank halt.
    always_comb begin
        stat = STAT_AOK;
        if (imem_error) begin
            stat = STAT_ADR;
        end else if (!instr_valid) begin
            stat = STAT_INS;
        end else if (dmem_error) begin
            stat = STAT_ADR;
        end else if (icode == IHALT) begin
            stat = STAT_HLT;
        end
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Y86-64 writeback stage: W pipeline register, regfile write ports, halt FSM and retire counter.
//
// Pipeline control: w_stall_i holds the W register (and blocks retirement and the halt transition
// for that cycle); w_bubble_i replaces the incoming instruction with a nop. Stall wins over bubble.
// There is no handshake beyond these two levels; regfile ports are combinational from W.
module wb_stage_pipe
    import y86_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int RADDR_W     = 4,
    parameter int CNT_W       = 32,
    parameter int STAT_STICKY = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               w_stall_i,
    input  logic               w_bubble_i,
    input  logic [3:0]         icode_i,
    input  logic [DATA_W-1:0]  valE_i,
    input  logic [DATA_W-1:0]  valM_i,
    input  logic [RADDR_W-1:0] dstE_i,
    input  logic [RADDR_W-1:0] dstM_i,
    input  logic               instr_valid_i,
    input  logic               imem_error_i,
    input  logic               dmem_error_i,
    output logic               rf_we_e_o,
    output logic [RADDR_W-1:0] rf_addr_e_o,
    output logic [DATA_W-1:0]  rf_data_e_o,
    output logic               rf_we_m_o,
    output logic [RADDR_W-1:0] rf_addr_m_o,
    output logic [DATA_W-1:0]  rf_data_m_o,
    output logic [RADDR_W-1:0] W_dstE_o,
    output logic [RADDR_W-1:0] W_dstM_o,
    output logic [DATA_W-1:0]  W_valE_o,
    output logic [DATA_W-1:0]  W_valM_o,
    output logic [2:0]         stat_o,
    output logic               halted_o,
    output logic [CNT_W-1:0]   retired_o
);

    // All-ones address at the configured width means "no write".
    localparam logic [RADDR_W-1:0] NO_REG = '1;

    // W pipeline register fields.
    logic [DATA_W-1:0]  w_valE;
    logic [DATA_W-1:0]  w_valM;
    logic [RADDR_W-1:0] w_dstE;
    logic [RADDR_W-1:0] w_dstM;
    stat_t              w_stat;
    logic               w_vld;

    stat_t              in_stat;

    wb_state_t          state;
    wb_state_t          state_nxt;
    stat_t              stat_hold;
    stat_t              stat_hold_nxt;
    logic [CNT_W-1:0]   retired;

    logic               w_aok_run;
    logic               do_retire;

    wb_stat_encode u_stat_encode (
        .icode       (icode_i),
        .instr_valid (instr_valid_i),
        .imem_error  (imem_error_i),
        .dmem_error  (dmem_error_i),
        .stat        (in_stat)
    );

    // W register: reset or bubble loads a nop, stall holds, otherwise capture the M-stage values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_valE <= '0;
            w_valM <= '0;
            w_dstE <= NO_REG;
            w_dstM <= NO_REG;
            w_stat <= STAT_AOK;
            w_vld  <= 1'b0;
        end else if (w_stall_i) begin
            w_valE <= w_valE;
            w_valM <= w_valM;
            w_dstE <= w_dstE;
            w_dstM <= w_dstM;
            w_stat <= w_stat;
            w_vld  <= w_vld;
        end else if (w_bubble_i) begin
            w_valE <= '0;
            w_valM <= '0;
            w_dstE <= NO_REG;
            w_dstM <= NO_REG;
            w_stat <= STAT_AOK;
            w_vld  <= 1'b0;
        end else begin
            w_valE <= valE_i;
            w_valM <= valM_i;
            w_dstE <= dstE_i;
            w_dstM <= dstM_i;
            w_stat <= in_stat;
            w_vld  <= 1'b1;
        end
    end

    // Halt FSM next state: the first valid faulting W instruction that is not stalled freezes the
    // machine and latches its status. With STAT_STICKY=0 the machine never leaves RUN.
    always_comb begin
        state_nxt     = state;
        stat_hold_nxt = stat_hold;
        if (state == S_RUN && STAT_STICKY != 0 && w_vld && w_stat != STAT_AOK && !w_stall_i) begin
            state_nxt     = S_HALTED;
            stat_hold_nxt = w_stat;
        end
    end

    // Halt FSM state and latched status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_RUN;
            stat_hold <= STAT_AOK;
        end else begin
            state     <= state_nxt;
            stat_hold <= stat_hold_nxt;
        end
    end

    assign w_aok_run = (w_stat == STAT_AOK) && (state == S_RUN);
    assign do_retire = w_vld && w_aok_run && !w_stall_i;

    // Retired-instruction counter; an instruction is counted as it leaves W, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired <= '0;
        end else if (do_retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Write enables. When both ports target the same register (popq %rsp) the memory value wins,
    // so the E port is dropped.
    always_comb begin
        rf_we_m_o = w_aok_run && (w_dstM != NO_REG);
        rf_we_e_o = w_aok_run && (w_dstE != NO_REG) && !(rf_we_m_o && (w_dstE == w_dstM));
    end

    assign rf_addr_e_o = w_dstE;
    assign rf_data_e_o = w_valE;
    assign rf_addr_m_o = w_dstM;
    assign rf_data_m_o = w_valM;

    assign W_dstE_o    = w_dstE;
    assign W_dstM_o    = w_dstM;
    assign W_valE_o    = w_valE;
    assign W_valM_o    = w_valM;

    assign stat_o      = (state == S_HALTED) ? stat_hold : w_stat;
    assign halted_o    = (state == S_HALTED);
    assign retired_o   = retired;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: default sticky instance plus a CNT_W=4, non-sticky instance.
module tb_wb_stage_pipe;

    localparam int DW = 64;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          bubble;
    logic [3:0]    icode;
    logic [DW-1:0] val_e;
    logic [DW-1:0] val_m;
    logic [AW-1:0] dst_e;
    logic [AW-1:0] dst_m;
    logic          valid;
    logic          imem_err;
    logic          dmem_err;

    logic          a_we_e, a_we_m, a_halted;
    logic [AW-1:0] a_addr_e, a_addr_m, a_w_dst_e, a_w_dst_m;
    logic [DW-1:0] a_data_e, a_data_m, a_w_val_e, a_w_val_m;
    logic [2:0]    a_stat;
    logic [31:0]   a_retired;

    logic          b_we_e, b_we_m, b_halted;
    logic [AW-1:0] b_addr_e, b_addr_m, b_w_dst_e, b_w_dst_m;
    logic [DW-1:0] b_data_e, b_data_m, b_w_val_e, b_w_val_m;
    logic [2:0]    b_stat;
    logic [3:0]    b_retired;

    int            n_cmp = 0;
    int            n_err = 0;

    // clock / reset block
    always #5 clk = ~clk;

    wb_stage_pipe u_dut (
        .clk_i(clk), .rst_i(rst), .w_stall_i(stall), .w_bubble_i(bubble),
        .icode_i(icode), .valE_i(val_e), .valM_i(val_m), .dstE_i(dst_e), .dstM_i(dst_m),
        .instr_valid_i(valid), .imem_error_i(imem_err), .dmem_error_i(dmem_err),
        .rf_we_e_o(a_we_e), .rf_addr_e_o(a_addr_e), .rf_data_e_o(a_data_e),
        .rf_we_m_o(a_we_m), .rf_addr_m_o(a_addr_m), .rf_data_m_o(a_data_m),
        .W_dstE_o(a_w_dst_e), .W_dstM_o(a_w_dst_m), .W_valE_o(a_w_val_e), .W_valM_o(a_w_val_m),
        .stat_o(a_stat), .halted_o(a_halted), .retired_o(a_retired)
    );

    wb_stage_pipe #(.CNT_W(4), .STAT_STICKY(0)) u_dut_ns (
        .clk_i(clk), .rst_i(rst), .w_stall_i(stall), .w_bubble_i(bubble),
        .icode_i(icode), .valE_i(val_e), .valM_i(val_m), .dstE_i(dst_e), .dstM_i(dst_m),
        .instr_valid_i(valid), .imem_error_i(imem_err), .dmem_error_i(dmem_err),
        .rf_we_e_o(b_we_e), .rf_addr_e_o(b_addr_e), .rf_data_e_o(b_data_e),
        .rf_we_m_o(b_we_m), .rf_addr_m_o(b_addr_m), .rf_data_m_o(b_data_m),
        .W_dstE_o(b_w_dst_e), .W_dstM_o(b_w_dst_m), .W_valE_o(b_w_val_e), .W_valM_o(b_w_val_m),
        .stat_o(b_stat), .halted_o(b_halted), .retired_o(b_retired)
    );

    // scoreboard check
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm, input logic vl,
                         input logic ie, input logic de_err);
        icode    = ic;
        val_e    = ve;
        val_m    = vm;
        dst_e    = de;
        dst_m    = dm;
        valid    = vl;
        imem_err = ie;
        dmem_err = de_err;
    endtask

    task automatic drive_nop();
        drive(4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        bubble = 1'b0;
        drive_nop();
        tick();
        tick();

        // reset state
        check_eq("rst_we_e", a_we_e, 0);
        check_eq("rst_we_m", a_we_m, 0);
        check_eq("rst_addr_e", a_addr_e, 4'hF);
        check_eq("rst_addr_m", a_addr_m, 4'hF);
        check_eq("rst_data_e", a_data_e, 0);
        check_eq("rst_stat", a_stat, 1);
        check_eq("rst_halted", a_halted, 0);
        check_eq("rst_retired", a_retired, 0);
        rst = 1'b0;

        // irmovq $5, %rbx
        drive(4'h3, 64'h5, 64'h0, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("irm_we_e", a_we_e, 1);
        check_eq("irm_addr_e", a_addr_e, 3);
        check_eq("irm_data_e", a_data_e, 5);
        check_eq("irm_we_m", a_we_m, 0);
        check_eq("irm_fwd_val_e", a_w_val_e, 5);

        // popq %rsp: only the M port writes
        drive(4'hB, 64'h108, 64'hAA, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("irm_retired", a_retired, 1);
        check_eq("pop_we_m", a_we_m, 1);
        check_eq("pop_addr_m", a_addr_m, 4);
        check_eq("pop_data_m", a_data_m, 64'hAA);
        check_eq("pop_we_e", a_we_e, 0);

        // stall 3 cycles with new inputs: W and counter frozen
        stall = 1'b1;
        drive(4'h3, 64'h77, 64'h0, 4'h7, 4'hF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_dst_e", a_w_dst_e, 4);
            check_eq("stall_data_m", a_data_m, 64'hAA);
            check_eq("stall_retired", a_retired, 1);
        end
        bubble = 1'b1;
        tick();
        check_eq("stall_bub_dst_m", a_w_dst_m, 4);
        check_eq("stall_bub_we_m", a_we_m, 1);
        check_eq("stall_bub_retired", a_retired, 1);
        stall = 1'b0;
        tick();
        check_eq("bub_we_e", a_we_e, 0);
        check_eq("bub_we_m", a_we_m, 0);
        check_eq("bub_dst_e", a_w_dst_e, 4'hF);
        check_eq("bub_retired", a_retired, 2);
        tick();
        check_eq("bub2_retired", a_retired, 2);
        bubble = 1'b0;

        // mrmovq with data-memory error
        drive(4'h5, 64'h0, 64'h33, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("adr_stat", a_stat, 3);
        check_eq("adr_we_m", a_we_m, 0);
        check_eq("adr_halted", a_halted, 0);
        drive(4'h3, 64'h9, 64'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("hlt1_halted", a_halted, 1);
        check_eq("hlt1_stat", a_stat, 3);
        check_eq("hlt1_we_e", a_we_e, 0);
        check_eq("hlt1_fwd_val_e", a_w_val_e, 9);
        drive(4'h3, 64'hA, 64'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("hlt2_we_e", a_we_e, 0);
        check_eq("hlt2_retired", a_retired, 2);
        check_eq("hlt2_fwd_val_e", a_w_val_e, 64'hA);

        // reset out of HALTED, then halt instruction
        rst = 1'b1;
        tick();
        check_eq("rst2_stat", a_stat, 1);
        check_eq("rst2_halted", a_halted, 0);
        check_eq("rst2_retired", a_retired, 0);
        rst = 1'b0;
        drive(4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("halt_stat", a_stat, 2);
        drive_nop();
        tick();
        check_eq("halt_halted", a_halted, 1);
        check_eq("halt_stat_sticky", a_stat, 2);
        rst = 1'b1;
        tick();
        check_eq("rst3_stat", a_stat, 1);
        check_eq("rst3_halted", a_halted, 0);
        check_eq("rst3_retired", a_retired, 0);
        rst = 1'b0;

        // status priority, observed on the non-sticky instance
        drive(4'h6, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1);
        tick();
        check_eq("prio_imem_over_ins", b_stat, 3);
        drive(4'h6, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("prio_ins_over_dmem", b_stat, 4);
        drive(4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("prio_dmem_over_hlt", b_stat, 3);
        drive(4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("prio_hlt", b_stat, 2);
        check_eq("ns_halted", b_halted, 0);

        // counter wrap on CNT_W=4 instance: 17 retirements -> 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            drive(4'h6, 64'(i), 64'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0);
            tick();
        end
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        check_eq("wrap_retired_ns", b_retired, 1);
        check_eq("wrap_retired", a_retired, 17);

        // non-sticky: INS then AOK
        drive(4'h6, 64'h1, 64'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("ns_ins_stat", b_stat, 4);
        check_eq("ns_ins_we_e", b_we_e, 0);
        drive(4'h6, 64'h2, 64'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("ns_aok_stat", b_stat, 1);
        check_eq("ns_aok_we_e", b_we_e, 1);
        check_eq("ns_aok_halted", b_halted, 0);
        check_eq("st_ins_stat", a_stat, 4);
        check_eq("st_ins_halted", a_halted, 1);
        check_eq("st_ins_retired", a_retired, 17);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
